if_stage: RTL and testbench

- Instruction-fetch stage of the 5-stage RISC-V pipeline, and the receiving end of the execute stage's redirect interface (`cancle`/`real_pc`).
- Owns the PC and issues one instruction-memory request at a time.
- Buffers the returned instruction and hands `{inst, pc}` to the decode stage under the valid/allowin handshake.
- On a redirect it discards all wrong-path work (outstanding request, buffered instruction) and restarts fetch at `real_pc`.

---
 rtl/if_stage.sv | 88 ++++++++
 tb/tb_if_stage.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, keeps one instruction-memory request in flight,
// buffers the returned word for decode, and restarts at real_pc on an execute redirect.
module if_stage #(
  parameter logic [31:0] RESET_PC         = 32'h0000_0000,
  parameter int          IF_TO_ID_DATA_WD = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        cancle,
  input  logic [31:0]                 real_pc,
  input  logic                        id_allowin,
  output logic                        if_to_id_valid,
  output logic [IF_TO_ID_DATA_WD-1:0] if_to_id_data,
  output logic                        inst_req_valid,
  input  logic                        inst_req_ready,
  output logic [31:0]                 inst_addr,
  input  logic                        inst_resp_valid,
  output logic                        inst_resp_ready,
  input  logic [31:0]                 inst_rdata
);

  typedef enum logic [1:0] {
    REQ  = 2'd0,
    WAIT = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t      state;
  logic [31:0] pc;
  logic [31:0] inst_buf;
  logic        drop;

  // Handshake outputs are gated by rst so nothing is offered or consumed while in reset,
  // even on the first reset cycle before the state register has been cleared.
  assign inst_req_valid  = rst && (state == REQ);
  assign inst_resp_ready = rst && (state == WAIT);
  assign if_to_id_valid  = rst && (state == HOLD) && !cancle;
  assign inst_addr       = pc;
  assign if_to_id_data   = IF_TO_ID_DATA_WD'({inst_buf, pc});

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= REQ;
      pc       <= RESET_PC;
      inst_buf <= 32'h0;
      drop     <= 1'b0;
    end else begin
      case (state)
        REQ: begin
          if (cancle) begin
            pc <= real_pc;
            // The request accepted this cycle carried the old pc; its response must be dropped.
            if (inst_req_ready) begin
              state <= WAIT;
              drop  <= 1'b1;
            end
          end else if (inst_req_ready) begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (inst_resp_valid && (drop || cancle)) begin
            drop  <= 1'b0;
            state <= REQ;
            if (cancle) pc <= real_pc;
          end else if (inst_resp_valid) begin
            inst_buf <= inst_rdata;
            state    <= HOLD;
          end else if (cancle) begin
            pc   <= real_pc;
            drop <= 1'b1;
          end
        end
        HOLD: begin
          if (cancle) begin
            pc    <= real_pc;
            state <= REQ;
          end else if (id_allowin) begin
            pc    <= pc + 32'd4;
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios, then random memory latency, back-pressure and
// redirects checked against an architectural model of the delivered {inst, pc} stream.
module tb_if_stage;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cancle = 1'b0;
  logic [31:0] real_pc = 32'h0;
  logic        id_allowin = 1'b0;
  logic        if_to_id_valid;
  logic [63:0] if_to_id_data;
  logic        inst_req_valid;
  logic        inst_req_ready = 1'b0;
  logic [31:0] inst_addr;
  logic        inst_resp_valid = 1'b0;
  logic        inst_resp_ready;
  logic [31:0] inst_rdata = 32'h0;

  if_stage #(.RESET_PC(RESET_PC), .IF_TO_ID_DATA_WD(64)) dut (
    .clk             (clk),
    .rst             (rst),
    .cancle          (cancle),
    .real_pc         (real_pc),
    .id_allowin      (id_allowin),
    .if_to_id_valid  (if_to_id_valid),
    .if_to_id_data   (if_to_id_data),
    .inst_req_valid  (inst_req_valid),
    .inst_req_ready  (inst_req_ready),
    .inst_addr       (inst_addr),
    .inst_resp_valid (inst_resp_valid),
    .inst_resp_ready (inst_resp_ready),
    .inst_rdata      (inst_rdata)
  );

  always #5 clk = ~clk;

  int          total = 0;
  int          bad = 0;
  int          deliveries = 0;
  // Memory model: one pending request, released after wait_cnt idle cycles.
  bit          pending = 0;
  logic [31:0] pend_addr = 32'h0;
  int          wait_cnt = 0;
  int          lat_cfg = 0;
  // Architectural model: pc of the next instruction decode should receive.
  logic [31:0] exp_pc = RESET_PC;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a * 32'h9E37_79B1 + 32'h0137_F00D;
  endfunction

  task automatic chk(input string tag, input logic [63:0] o, input logic [63:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  task automatic step(input logic r, input logic rdy, input logic allow,
                      input logic cn, input logic [31:0] rpc);
    @(negedge clk);
    rst             = r;
    inst_req_ready  = rdy;
    id_allowin      = allow;
    cancle          = cn;
    real_pc         = rpc;
    inst_resp_valid = pending && (wait_cnt == 0);
    inst_rdata      = inst_resp_valid ? mem_word(pend_addr) : 32'hDEAD_BEEF;
    #1;
    if (!rst) begin
      chk("reset_outputs_low", {61'h0, inst_req_valid, inst_resp_ready, if_to_id_valid}, 64'h0);
      exp_pc = RESET_PC;
    end else begin
      if (if_to_id_valid) chk("valid_while_cancle", {63'h0, cancle}, 64'h0);
      if (if_to_id_valid && id_allowin) begin
        chk("delivered_inst_pc", if_to_id_data, {mem_word(exp_pc), exp_pc});
        exp_pc = exp_pc + 32'd4;
        deliveries++;
      end
      if (cancle) exp_pc = real_pc;
      if (inst_resp_ready) chk("resp_ready_without_request", {63'h0, pending}, 64'h1);
    end
    if (inst_resp_valid && inst_resp_ready) pending = 0;
    else if (pending && wait_cnt > 0) wait_cnt--;
    if (inst_req_valid && inst_req_ready) begin
      chk("second_outstanding_request", {63'h0, pending}, 64'h0);
      pending   = 1;
      pend_addr = inst_addr;
      wait_cnt  = (lat_cfg < 0) ? int'($urandom_range(0, 3)) : lat_cfg;
    end
  endtask

  initial begin
    // Reset held, then released with an always-ready memory answering next cycle.
    lat_cfg = 0;
    repeat (3) step(0, 0, 0, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("t1_req0", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h0});
    step(1, 1, 1, 0, 32'h0);
    chk("t1_resp_ready0", {63'h0, inst_resp_ready}, 64'h1);
    step(1, 1, 1, 0, 32'h0);
    chk("t1_valid0", {63'h0, if_to_id_valid}, 64'h1);
    chk("t1_data0", if_to_id_data, {mem_word(32'h0), 32'h0});
    step(1, 1, 1, 0, 32'h0);
    chk("t1_req4", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h4});
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("t1_data4", {63'h0, if_to_id_valid}, 64'h1);
    chk("t1_data4", if_to_id_data, {mem_word(32'h4), 32'h4});
    step(1, 1, 1, 0, 32'h0);
    chk("t1_req8", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h8});
    step(1, 1, 0, 0, 32'h0);

    // Decode stalls while the instruction at 0x8 is buffered.
    for (int i = 0; i < 6; i++) begin
      step(1, 1, 0, 0, 32'h0);
      chk("t2_hold_valid", {62'h0, if_to_id_valid, inst_req_valid}, {62'h0, 2'b10});
      chk("t2_hold_data", if_to_id_data, {mem_word(32'h8), 32'h8});
    end
    step(1, 1, 1, 0, 32'h0);
    lat_cfg = 2;
    step(1, 1, 1, 0, 32'h0);
    chk("t2_reqC", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'hC});

    // Redirect while waiting; the late response must be swallowed.
    step(1, 0, 1, 1, 32'h100);
    chk("t3_wait", {63'h0, inst_resp_ready}, 64'h1);
    for (int i = 0; i < 10; i++) begin
      step(1, 0, 1, 0, 32'h0);
      chk("t3_no_valid", {63'h0, if_to_id_valid}, 64'h0);
      if (inst_req_valid) break;
    end
    chk("t3_req100", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h100});
    lat_cfg = 0;
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    chk("t3_first_pc100", {63'h0, if_to_id_valid}, 64'h1);
    chk("t3_first_pc100", if_to_id_data, {mem_word(32'h100), 32'h100});

    // Redirect in the same cycle as the response.
    step(1, 1, 1, 0, 32'h0);
    chk("t4_req104", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h104});
    step(1, 0, 1, 1, 32'h200);
    chk("t4_resp_hs", {62'h0, inst_resp_valid, inst_resp_ready}, {62'h0, 2'b11});
    step(1, 0, 1, 0, 32'h0);
    chk("t4_req200", {30'h0, if_to_id_valid, inst_req_valid, inst_addr},
        {30'h0, 2'b01, 32'h200});

    // Redirect while holding with decode ready.
    step(1, 1, 1, 0, 32'h0);
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 1, 32'h40);
    chk("t5_valid_gated", {63'h0, if_to_id_valid}, 64'h0);
    chk("t5_buffered", if_to_id_data, {mem_word(32'h200), 32'h200});
    step(1, 0, 1, 0, 32'h0);
    chk("t5_req40", {31'h0, inst_req_valid, inst_addr}, {31'h0, 1'b1, 32'h40});

    // Reset while a request is outstanding; stale response must not be acknowledged.
    lat_cfg = 3;
    step(1, 1, 1, 0, 32'h0);
    step(1, 0, 1, 0, 32'h0);
    chk("t6_wait", {63'h0, inst_resp_ready}, 64'h1);
    step(0, 0, 1, 0, 32'h0);
    for (int i = 0; i < 4; i++) begin
      step(1, 0, 1, 0, 32'h0);
      chk("t6_stale_ignored", {30'h0, inst_resp_ready, inst_req_valid, inst_addr},
          {30'h0, 2'b01, RESET_PC});
    end
    pending = 0;

    // Random traffic: latency, back-pressure and redirects, wrap-around targets included.
    lat_cfg = -1;
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, allow, cn;
      logic [31:0] rpc;
      int          sel;
      rdy   = ($urandom_range(0, 9) < 7);
      allow = ($urandom_range(0, 9) < 7);
      cn    = ($urandom_range(0, 99) < 4);
      sel   = $urandom_range(0, 3);
      rpc   = (sel == 0) ? 32'hFFFF_FFF8 : (sel == 1) ? 32'hFFFF_FFFC
                                          : ($urandom() & 32'hFFFF_FFFC);
      step(1, rdy, allow, cn, rpc);
    end
    chk("forward_progress", {63'h0, deliveries >= 150}, 64'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
